// File: rtl/relobi_r_fault_ctrl.sv
// ============================================================================
//  Module   : relobi_r_fault_ctrl
//  Purpose  : Fault supervisor for the TMR-voted OBI R channel. It counts voted
//             faults and, when they cluster, drains traffic and resyncs the
//             replicas. Optional RESYNC watchdog: RELOBI_R_FAULT_CTRL_TIMEOUT_EN
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module relobi_r_fault_ctrl #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned FAULT_CNT_WIDTH = 16,
  parameter int unsigned WINDOW_CYCLES   = 1024,
  parameter int unsigned THRESHOLD       = 3,
  parameter int unsigned COOLDOWN_CYCLES = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       req_i,
  input  logic                       gnt_i,
  input  logic                       rvalid_i,
  input  logic                       fault_i,
  input  logic                       resync_ack_i,
  input  logic                       clear_cnt_i,
  output logic                       hold_o,
  output logic                       resync_req_o,
  output logic [FAULT_CNT_WIDTH-1:0] fault_cnt_o,
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
  output logic                       timeout_o,
`endif
  output logic [2:0]                 state_o
);

  localparam int unsigned OW        = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned TIMER_MAX = (4 * WINDOW_CYCLES > COOLDOWN_CYCLES) ?
                                      4 * WINDOW_CYCLES : COOLDOWN_CYCLES;
  localparam int unsigned TW        = $clog2(TIMER_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WINDOW   = 3'd1,
    S_DRAIN    = 3'd2,
    S_RESYNC   = 3'd3,
    S_COOLDOWN = 3'd4
  } state_t;

  state_t                     r_state;
  logic [OW-1:0]              r_outst;
  logic [FAULT_CNT_WIDTH-1:0] r_fault_cnt;
  logic [7:0]                 r_win_cnt;
  logic [TW-1:0]              r_timer;
  logic                       r_hold;
  logic                       r_resync_req;
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
  logic                       r_timeout;
`endif

  logic          w_inc;
  logic          w_dec;
  logic          w_fault_beat;
  logic [OW-1:0] w_outst_next;
  logic [7:0]    w_win_next;

  assign w_inc        = req_i & gnt_i & ~r_hold;
  assign w_dec        = rvalid_i;
  assign w_fault_beat = rvalid_i & fault_i;
  assign w_win_next   = r_win_cnt + {7'd0, w_fault_beat};

  // Saturating outstanding count; DRAIN looks at the next value so the
  // resync request follows the final response by one cycle.
  always_comb begin
    w_outst_next = r_outst;
    if (w_inc && !w_dec && r_outst != OW'(MAX_OUTSTANDING)) begin
      w_outst_next = r_outst + OW'(1);
    end else if (w_dec && !w_inc && r_outst != '0) begin
      w_outst_next = r_outst - OW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_outst      <= '0;
      r_fault_cnt  <= '0;
      r_win_cnt    <= '0;
      r_timer      <= '0;
      r_hold       <= 1'b0;
      r_resync_req <= 1'b0;
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
      r_timeout    <= 1'b0;
`endif
    end else begin
      r_outst <= w_outst_next;
      if (clear_cnt_i) begin
        r_fault_cnt <= '0;
      end else if (w_fault_beat && !(&r_fault_cnt)) begin
        r_fault_cnt <= r_fault_cnt + FAULT_CNT_WIDTH'(1);
      end
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
      r_timeout <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (w_fault_beat) begin
            if (THRESHOLD == 1) begin
              r_state <= S_DRAIN;
              r_hold  <= 1'b1;
            end else begin
              r_win_cnt <= 8'd1;
              r_timer   <= TW'(WINDOW_CYCLES - 1);
              r_state   <= S_WINDOW;
            end
          end
        end
        S_WINDOW: begin
          // Threshold takes precedence over the window closing in the same cycle.
          if (w_fault_beat && w_win_next >= 8'(THRESHOLD)) begin
            r_state   <= S_DRAIN;
            r_hold    <= 1'b1;
            r_win_cnt <= '0;
          end else if (r_timer == '0) begin
            r_state   <= S_IDLE;
            r_win_cnt <= '0;
          end else begin
            r_timer   <= r_timer - TW'(1);
            r_win_cnt <= w_win_next;
          end
        end
        S_DRAIN: begin
          if (w_outst_next == '0) begin
            r_state      <= S_RESYNC;
            r_resync_req <= 1'b1;
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
            r_timer      <= TW'(4 * WINDOW_CYCLES - 1);
`endif
          end
        end
        S_RESYNC: begin
          if (resync_ack_i) begin
            r_state      <= S_COOLDOWN;
            r_resync_req <= 1'b0;
            r_hold       <= 1'b0;
            r_timer      <= TW'(COOLDOWN_CYCLES - 1);
          end
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
          else if (r_timer == '0) begin
            r_state      <= S_COOLDOWN;
            r_resync_req <= 1'b0;
            r_hold       <= 1'b0;
            r_timeout    <= 1'b1;
            r_timer      <= TW'(COOLDOWN_CYCLES - 1);
          end else begin
            r_timer <= r_timer - TW'(1);
          end
`endif
        end
        S_COOLDOWN: begin
          if (r_timer == '0) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  a_outst_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_inc && !w_dec && r_outst == OW'(MAX_OUTSTANDING)));
  a_outst_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_dec && !w_inc && r_outst == '0));

  assign hold_o       = r_hold;
  assign resync_req_o = r_resync_req;
  assign fault_cnt_o  = r_fault_cnt;
  assign state_o      = r_state;
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
  assign timeout_o    = r_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_relobi_r_fault_ctrl.sv
// Bench for relobi_r_fault_ctrl: vector table, fault-count scoreboard, corner sequences.
`default_nettype none

module tb_relobi_r_fault_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0, gnt = 1'b0, rv = 1'b0, flt = 1'b0, ack = 1'b0, clr = 1'b0;
  logic        hold, rsq;
  logic [15:0] cnt;
  logic [2:0]  state;
  logic        s_req = 1'b0, s_gnt = 1'b0, s_rv = 1'b0, s_flt = 1'b0;
  logic        s_hold, s_rsq;
  logic [3:0]  s_cnt;
  logic [2:0]  s_state;
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
  logic        tmo, s_tmo;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int m_cnt    = 0;
  int sb[$];

  always #5 clk = ~clk;

  relobi_r_fault_ctrl u_dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_i(gnt), .rvalid_i(rv),
    .fault_i(flt), .resync_ack_i(ack), .clear_cnt_i(clr), .hold_o(hold),
    .resync_req_o(rsq), .fault_cnt_o(cnt),
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
    .timeout_o(tmo),
`endif
    .state_o(state)
  );

  relobi_r_fault_ctrl #(.FAULT_CNT_WIDTH(4), .THRESHOLD(255)) u_sat (
    .clk_i(clk), .rst_i(rst), .req_i(s_req), .gnt_i(s_gnt), .rvalid_i(s_rv),
    .fault_i(s_flt), .resync_ack_i(1'b0), .clear_cnt_i(1'b0), .hold_o(s_hold),
    .resync_req_o(s_rsq), .fault_cnt_o(s_cnt),
`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
    .timeout_o(s_tmo),
`endif
    .state_o(s_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock: drive inputs, push the expected fault count, compare after the edge.
  task automatic cycle(input logic i_rq, i_gn, i_rv, i_fl, i_cl, i_ak);
    req = i_rq; gnt = i_gn; rv = i_rv; flt = i_fl; clr = i_cl; ack = i_ak;
    if (rst || i_cl) m_cnt = 0;
    else if (i_rv && i_fl && m_cnt != 65535) m_cnt++;
    sb.push_back(m_cnt);
    @(posedge clk); #1;
    chk("fault_cnt", {16'd0, cnt}, sb.pop_front());
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(); idle();
    rst = 1'b0;
    chk("rst_state", {29'd0, state}, 0);
    chk("rst_hold", {31'd0, hold}, 0);
    chk("rst_resync", {31'd0, rsq}, 0);
  endtask

  typedef struct packed {
    logic rq, gn, rv, fl, cl, ak;
    logic [2:0] st;
    logic hd, rs;
  } vec_t;
  vec_t tbl[27];

  initial begin
    int n;
    logic saw_hold;
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0, 1'b0};
    for (int i = 11; i < 26; i++)
      tbl[i] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0};

    do_reset();
    chk("rst_cnt", {16'd0, cnt}, 0);
    for (int i = 0; i < 27; i++) begin
      cycle(tbl[i].rq, tbl[i].gn, tbl[i].rv, tbl[i].fl, tbl[i].cl, tbl[i].ak);
      chk($sformatf("vec%0d_state", i), {29'd0, state}, {29'd0, tbl[i].st});
      chk($sformatf("vec%0d_hold", i), {31'd0, hold}, {31'd0, tbl[i].hd});
      chk($sformatf("vec%0d_resync", i), {31'd0, rsq}, {31'd0, tbl[i].rs});
    end

    // Trigger with two outstanding; blocked request must not delay resync.
    do_reset();
    cycle(1, 1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 1, 0, 0);
    chk("trig_state", {29'd0, state}, 2);
    chk("trig_hold", {31'd0, hold}, 1);
    cycle(1, 1, 0, 0, 0, 0);
    chk("blocked_state", {29'd0, state}, 2);
    cycle(0, 0, 1, 0, 0, 0);
    chk("drain1_resync", {31'd0, rsq}, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("drain_done_state", {29'd0, state}, 3);
    chk("drain_done_resync", {31'd0, rsq}, 1);
    repeat (5) idle();
    chk("wait_ack_resync", {31'd0, rsq}, 1);
    cycle(0, 0, 0, 0, 0, 1);
    chk("ack_state", {29'd0, state}, 4);
    chk("ack_resync", {31'd0, rsq}, 0);
    chk("ack_hold", {31'd0, hold}, 0);
    n = 1;
    while (state == 3'd4 && n < 40) begin
      idle();
      if (state == 3'd4) n++;
    end
    chk("cooldown_len", n, 16);
    chk("cooldown_exit", {29'd0, state}, 0);

    // Two faults 100 cycles apart: window closes after 1024 cycles, no hold.
    do_reset();
    cycle(1, 1, 0, 0, 0, 0); cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    n = (state == 3'd1) ? 1 : 0;
    saw_hold = 1'b0;
    while (state == 3'd1 && n < 1100) begin
      if (n == 100) cycle(0, 0, 1, 1, 0, 0);
      else idle();
      saw_hold = saw_hold | hold;
      if (state == 3'd1) n++;
    end
    chk("window_len", n, 1024);
    chk("subthr_state", {29'd0, state}, 0);
    chk("subthr_hold", {31'd0, saw_hold}, 0);
    chk("subthr_cnt", {16'd0, cnt}, 2);

    // Threshold reached on the window's final cycle, then reset from RESYNC.
    do_reset();
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 1023; k++) begin
      if (k == 500) cycle(0, 0, 1, 1, 0, 0);
      else idle();
    end
    chk("last_cycle_pre", {29'd0, state}, 1);
    cycle(0, 0, 1, 1, 0, 0);
    chk("last_cycle_drain", {29'd0, state}, 2);
    idle();
    chk("last_cycle_resync", {29'd0, state}, 3);
    rst = 1'b1;
    cycle(1, 1, 0, 0, 0, 0);
    chk("midrst_state", {29'd0, state}, 0);
    chk("midrst_hold", {31'd0, hold}, 0);
    chk("midrst_resync", {31'd0, rsq}, 0);
    cycle(1, 1, 0, 0, 0, 0);
    rst = 1'b0;

`ifdef RELOBI_R_FAULT_CTRL_TIMEOUT_EN
    do_reset();
    cycle(1, 1, 0, 0, 0, 0);
    repeat (3) cycle(1, 1, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    chk("to_enter", {29'd0, state}, 3);
    n = 0;
    while (state == 3'd3 && n < 5000) begin
      idle();
      n++;
    end
    chk("to_len", n, 4096);
    chk("to_pulse", {31'd0, tmo}, 1);
    chk("to_resync", {31'd0, rsq}, 0);
    chk("to_hold", {31'd0, hold}, 0);
    chk("to_state", {29'd0, state}, 4);
    idle();
    chk("to_pulse_end", {31'd0, tmo}, 0);
`endif

    // Saturation on the 4-bit instance.
    do_reset();
    s_req = 1'b1; s_gnt = 1'b1;
    @(posedge clk); #1;
    s_rv = 1'b1; s_flt = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sat_%0d", k), {28'd0, s_cnt}, (k > 15) ? 15 : k);
    end
    s_req = 1'b0; s_gnt = 1'b0; s_rv = 1'b0; s_flt = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("sat_rst", {28'd0, s_cnt}, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/relobi_r_fault_ctrl.md
Name: relobi_r_fault_ctrl

Overview:
- Supervises the TMR-voted OBI R channel of a reliable OBI (relobi) port.
- Consumes the voter's aggregated fault flag once per accepted response beat and keeps a total fault counter.
- When faults cluster inside a time window, it drains outstanding transactions, holds off new requests, runs a resync handshake with the replicated subordinate logic, then resumes traffic.
- Sits between the R-channel voter and the manager-side request path.

Parameters:
- MaxOutstanding, 4, maximum in-flight OBI transactions tracked; counter width is $clog2(MaxOutstanding+1).
- FaultCntWidth, 16, width of the saturating total-fault counter.
- WindowCycles, 1024, length of the fault-clustering window in cycles (>=2).
- Threshold, 3, faults within one window that trigger a resync (1..255).
- CooldownCycles, 16, cycles of guaranteed normal operation after a resync (>=1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  1  manager request valid (A channel).
- gnt_i  in  1  subordinate grant (A channel).
- rvalid_i  in  1  voted response beat valid.
- fault_i  in  1  voter fault flag, sampled only when rvalid_i=1.
- resync_ack_i  in  1  replicas report resync complete.
- clear_cnt_i  in  1  clears fault_cnt_o.
- hold_o  out  1  gates req_i toward the subordinate (1 = block new requests).
- resync_req_o  out  1  resync request to the replicas.
- fault_cnt_o  out  FaultCntWidth  saturating total of faulty beats.
- state_o  out  3  FSM state encoding for debug.

Behaviour:
- Reset values: hold_o=0, resync_req_o=0, fault_cnt_o=0, state_o=IDLE (0); outstanding=0, window count=0, timers=0.
- Outstanding counter:
  - +1 on req_i&gnt_i&!hold_o; -1 on rvalid_i; both in the same cycle leaves it unchanged.
  - Increment at MaxOutstanding and decrement at 0 are protocol errors; the counter saturates and is covered by assertions.
- Fault counter:
  - +1 each cycle rvalid_i&fault_i; saturates at all-ones.
  - clear_cnt_i has priority over an increment in the same cycle (result 0).
  - Outputs are registered: a fault is visible one cycle later.
- States: IDLE=0, WINDOW=1, DRAIN=2, RESYNC=3, COOLDOWN=4.
  - IDLE: on a faulty beat, window count:=1, timer:=WindowCycles-1, go to WINDOW. If Threshold==1, go directly to DRAIN instead.
  - WINDOW: timer decrements each cycle and each faulty beat increments the window count. When the count reaches Threshold, go to DRAIN. Threshold reached and timer expiry in the same cycle: DRAIN wins. Timer reaches 0 without reaching Threshold: window count:=0, go to IDLE.
  - DRAIN: hold_o=1, registered, asserted from the first DRAIN cycle. Once outstanding==0, go to RESYNC. Entry with outstanding already 0 spends exactly one cycle in DRAIN.
  - RESYNC: hold_o=1, resync_req_o=1 and held until resync_ack_i=1. On ack: resync_req_o drops next cycle, timer:=CooldownCycles-1, go to COOLDOWN. An ack outside RESYNC is ignored.
  - COOLDOWN: hold_o=0. Faulty beats are counted in fault_cnt_o but do not open a window. Timer reaches 0: go to IDLE.
- Faulty beats in DRAIN/RESYNC are counted in fault_cnt_o only.
- rst_i mid-operation (any state): everything returns to reset values next cycle, including dropping resync_req_o. Replicas must tolerate an abandoned request.
- Latency:
  - Threshold-th faulty beat at cycle t: state_o=DRAIN and hold_o=1 at t+1.
  - Final rvalid_i at cycle u: resync_req_o=1 at u+1.

Optional Feature:
- Macro: RELOBI_R_FAULT_CTRL_TIMEOUT_EN.
- When defined:
  - Adds port timeout_o (out, 1).
  - RESYNC has a watchdog of 4*WindowCycles cycles. On expiry: timeout_o pulses for 1 cycle, resync_req_o drops, state goes to COOLDOWN, and hold_o is released.
- When undefined: RESYNC waits indefinitely for resync_ack_i and the port is absent.

Test Plan:
- Reset: assert rst_i for 2 cycles mid-traffic -> all outputs 0 and state_o=0 on the next cycle.
- Sub-threshold: Threshold=3; 2 faulty beats 100 cycles apart, no more for 1024 cycles -> state_o returns to 0, fault_cnt_o=2, hold_o never 1.
- Trigger with drain: 2 outstanding, 3 faulty beats within the window -> hold_o=1 next cycle; new req_i&gnt_i not counted while hold_o=1; resync_req_o=1 one cycle after the last rvalid_i; ack after 5 cycles -> COOLDOWN for 16 cycles, then IDLE.
- Same-cycle events:
  - req_i&gnt_i with rvalid_i -> outstanding unchanged.
  - clear_cnt_i with a faulty beat -> fault_cnt_o=0.
  - Threshold hit on the timer's last cycle -> DRAIN.
- Saturation: FaultCntWidth=4; 20 faulty beats -> fault_cnt_o=15.
- Timeout (macro defined): no ack for 4096 cycles -> timeout_o one-cycle pulse, resync_req_o=0, state_o=4.
